inst_fetch_responder: RTL and testbench

//  Memory-side responder for the CPU instruction-fetch interface. Serves PC fetch requests

---
 rtl/inst_fetch_responder_pkg.sv | 17 +
 rtl/inst_fetch_responder_resp_fifo.sv | 54 +++++
 rtl/inst_fetch_responder.sv | 105 ++++++++++
 tb/tb_inst_fetch_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_responder_pkg.sv
// Shared types for the instruction-fetch responder: widths, the NOP word
// and the response record carried through the delay line and response FIFO.
package inst_fetch_responder_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] inst;
    logic              err;
  } rsp_rec_t;

  localparam int REC_W = $bits(rsp_rec_t);

endpackage

// File: rtl/inst_fetch_responder_resp_fifo.sv
// Synchronous response FIFO with async reset and a flush that empties it in one edge.
// Push and pop may coincide at any occupancy; the caller never pops when empty.
module inst_fetch_responder_resp_fifo
  import inst_fetch_responder_pkg::*;
#(
  parameter int WIDTH = REC_W,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + AW'(1);
      if (pop_i)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Data array carries no reset; the top masks the head while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) storage[wr_ptr] <= wdata_i;
  end

  assign rdata_o = storage[rd_ptr];
  assign empty_o = (count == '0);

endmodule

// File: rtl/inst_fetch_responder.sv
// Memory-side responder for instruction fetch: looks up the word at accept,
// delays it LATENCY cycles, then queues it in order for the IF/ID consumer.
module inst_fetch_responder
  import inst_fetch_responder_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int LATENCY   = 2,
  parameter int QDEPTH    = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              flush_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [INST_W-1:0] rsp_inst_o,
  output logic [ADDR_W-1:0] rsp_addr_o,
  output logic              rsp_err_o
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam logic [ADDR_W-3:0] MEM_LIMIT = (ADDR_W-2)'(MEM_WORDS);

  logic [INST_W-1:0] mem [0:MEM_WORDS-1];

  logic [CNT_W-1:0]   outstanding;
  logic [LATENCY-1:0] dl_v;
  rsp_rec_t           dl_r [LATENCY];
  logic [ADDR_W-3:0]  word_idx;
  rsp_rec_t           lookup;
  rsp_rec_t           head;
  logic [REC_W-1:0]   fifo_rdata;
  logic               fifo_empty;
  logic               accept;
  logic               rsp_hs;

  // Handshakes: a transfer happens on the rising edge where valid && ready;
  // ready never looks at valid, and valid/payload hold until the transfer.
  assign req_ready_o = !rst_i && !flush_i && (outstanding < CNT_W'(QDEPTH));
  assign accept      = req_valid_i && req_ready_o;
  assign rsp_valid_o = !fifo_empty && !flush_i;
  assign rsp_hs      = rsp_valid_o && rsp_ready_i;

  always_comb begin
    word_idx    = req_addr_i[ADDR_W-1:2];
    lookup.addr = req_addr_i;
    lookup.err  = (req_addr_i[1:0] != 2'b00) || (word_idx >= MEM_LIMIT);
    lookup.inst = NOP_INST;
    if (!lookup.err) lookup.inst = mem[word_idx[IDX_W-1:0]];
  end

  // Outstanding credit covers delay line plus FIFO, so a push never meets a full FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding <= '0;
    end else if (flush_i) begin
      outstanding <= '0;
    end else begin
      case ({accept, rsp_hs})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dl_v <= '0;
    end else if (flush_i) begin
      dl_v <= '0;
    end else begin
      dl_v[0] <= accept;
      for (int i = 1; i < LATENCY; i++) dl_v[i] <= dl_v[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    dl_r[0] <= lookup;
    for (int i = 1; i < LATENCY; i++) dl_r[i] <= dl_r[i-1];
  end

  inst_fetch_responder_resp_fifo #(
    .WIDTH (REC_W),
    .DEPTH (QDEPTH)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (dl_v[LATENCY-1]),
    .wdata_i (dl_r[LATENCY-1]),
    .pop_i   (rsp_hs),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty)
  );

  assign head       = rsp_rec_t'(fifo_rdata);
  assign rsp_inst_o = fifo_empty ? '0 : head.inst;
  assign rsp_addr_o = fifo_empty ? '0 : head.addr;
  assign rsp_err_o  = fifo_empty ? 1'b0 : head.err;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder: linear stimulus steps with immediate
// assertions, plus an in-order response scoreboard fed from an expected queue.
module tb_inst_fetch_responder;

  logic        clk_i;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        flush_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_inst_o;
  logic [31:0] rsp_addr_o;
  logic        rsp_err_o;

  int checks;
  int failures;
  logic [64:0] exp_q[$];
  logic [7:0]  vbits;

  inst_fetch_responder #(
    .MEM_WORDS (256),
    .LATENCY   (2),
    .QDEPTH    (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .flush_i     (flush_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_inst_o  (rsp_inst_o),
    .rsp_addr_o  (rsp_addr_o),
    .rsp_err_o   (rsp_err_o)
  );

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [31:0] mem_model(int i);
    return (i == 1) ? 32'h2001_0005 : (32'hA500_0000 | 32'(i));
  endfunction

  function automatic logic [64:0] exp_rec(logic [31:0] addr);
    logic [29:0] idx;
    logic        err;
    idx = addr[31:2];
    err = (addr[1:0] != 2'b00) || (idx >= 30'd256);
    return {addr, (err ? 32'h0 : mem_model(int'(idx))), err};
  endfunction

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req(input logic valid, input logic [31:0] addr);
    req_valid_i = valid;
    req_addr_i  = addr;
  endtask

  task automatic chk_head(input string tag, input logic [64:0] exp);
    chk({tag, "_valid"}, 65'(rsp_valid_o), 65'd1);
    chk(tag, {rsp_addr_o, rsp_inst_o, rsp_err_o}, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 65'(req_ready_o), 65'd0);
    chk({tag, "_rsp_valid"}, 65'(rsp_valid_o), 65'd0);
    chk({tag, "_rsp_data"}, {rsp_addr_o, rsp_inst_o, rsp_err_o}, 65'd0);
  endtask

  // scoreboard: every completed response handshake must match the queue head
  always @(negedge clk_i) begin
    if (!rst_i && rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0)
        chk("rsp_unexpected", 65'(rsp_valid_o), 65'd0);
      else
        chk("rsp_order", {rsp_addr_o, rsp_inst_o, rsp_err_o}, exp_q.pop_front());
    end
  end

  initial begin
    checks      = 0;
    failures    = 0;
    rst_i       = 1'b1;
    flush_i     = 1'b0;
    rsp_ready_i = 1'b1;
    drive_req(1'b0, 32'h0);
    for (int i = 0; i < 256; i++) dut.mem[i] = mem_model(i);

    // reset state
    tick();
    tick();
    chk_all_zero("reset_init");
    rst_i = 1'b0;
    #1;
    chk("reset_release_ready", 65'(req_ready_o), 65'd1);

    // single fetch, latency of exactly 2 cycles
    exp_q.push_back(exp_rec(32'h4));
    drive_req(1'b1, 32'h4);
    tick();
    drive_req(1'b0, 32'h0);
    chk("single_lat0", 65'(rsp_valid_o), 65'd0);
    tick();
    chk("single_lat1", 65'(rsp_valid_o), 65'd0);
    tick();
    chk_head("single_rsp", {32'h4, 32'h2001_0005, 1'b0});
    tick();
    chk("single_popped", 65'(rsp_valid_o), 65'd0);

    // streaming: 5 back-to-back accepts give 5 back-to-back responses
    vbits = '0;
    for (int c = 0; c < 8; c++) begin
      if (c < 5) begin
        drive_req(1'b1, 32'(4 * c));
        exp_q.push_back(exp_rec(32'(4 * c)));
      end else begin
        drive_req(1'b0, 32'h0);
      end
      tick();
      vbits[c] = rsp_valid_o;
    end
    chk("stream_valid_pattern", 65'(vbits), 65'h7C);
    chk("stream_drained", 65'(exp_q.size()), 65'd0);

    // backpressure: only QDEPTH accepted, head held stable
    rsp_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive_req(1'b1, 32'h20 + 32'(4 * c));
      exp_q.push_back(exp_rec(32'h20 + 32'(4 * c)));
      chk("bp_ready_on", 65'(req_ready_o), 65'd1);
      tick();
    end
    drive_req(1'b1, 32'h30);
    exp_q.push_back(exp_rec(32'h30));
    for (int c = 0; c < 4; c++) begin
      chk("bp_ready_off", 65'(req_ready_o), 65'd0);
      tick();
      if (c == 0) chk_head("bp_head_early", {32'h20, 32'hA500_0008, 1'b0});
    end
    chk_head("bp_head_late", {32'h20, 32'hA500_0008, 1'b0});
    rsp_ready_i = 1'b1;
    #1;
    chk("bp_still_full", 65'(req_ready_o), 65'd0);
    tick();
    chk("bp_credit_back", 65'(req_ready_o), 65'd1);
    tick();
    drive_req(1'b1, 32'h34);
    exp_q.push_back(exp_rec(32'h34));
    tick();
    drive_req(1'b0, 32'h0);
    repeat (8) tick();
    chk("bp_drained", 65'(exp_q.size()), 65'd0);

    // error cases and the last valid word
    drive_req(1'b1, 32'h6);
    exp_q.push_back(exp_rec(32'h6));
    tick();
    drive_req(1'b1, 32'h400);
    exp_q.push_back(exp_rec(32'h400));
    tick();
    drive_req(1'b1, 32'h3FC);
    exp_q.push_back(exp_rec(32'h3FC));
    tick();
    drive_req(1'b0, 32'h0);
    chk_head("err_misaligned", {32'h6, 32'h0, 1'b1});
    tick();
    chk_head("err_out_of_range", {32'h400, 32'h0, 1'b1});
    tick();
    chk_head("last_word", {32'h3FC, 32'hA500_00FF, 1'b0});
    repeat (3) tick();
    chk("err_drained", 65'(exp_q.size()), 65'd0);

    // flush with 1 entry in the FIFO and 2 in the delay line
    rsp_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive_req(1'b1, 32'h40 + 32'(4 * c));
      tick();
    end
    flush_i = 1'b1;
    drive_req(1'b1, 32'h4C);
    #1;
    chk("flush_ready_low", 65'(req_ready_o), 65'd0);
    chk("flush_valid_low", 65'(rsp_valid_o), 65'd0);
    tick();
    flush_i     = 1'b0;
    rsp_ready_i = 1'b1;
    exp_q.push_back(exp_rec(32'h4C));
    #1;
    chk("post_flush_ready", 65'(req_ready_o), 65'd1);
    tick();
    drive_req(1'b0, 32'h0);
    chk("post_flush_lat0", 65'(rsp_valid_o), 65'd0);
    tick();
    chk("post_flush_lat1", 65'(rsp_valid_o), 65'd0);
    tick();
    chk_head("post_flush_rsp", {32'h4C, 32'hA500_0013, 1'b0});
    repeat (3) tick();
    chk("flush_drained", 65'(exp_q.size()), 65'd0);

    // reset mid-stream with 3 outstanding
    rsp_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive_req(1'b1, 32'h50 + 32'(4 * c));
      tick();
    end
    rst_i = 1'b1;
    drive_req(1'b0, 32'h0);
    #1;
    chk_all_zero("reset_mid");
    tick();
    tick();
    rst_i       = 1'b0;
    rsp_ready_i = 1'b1;
    #1;
    chk("reset_mid_ready", 65'(req_ready_o), 65'd1);
    vbits = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      vbits[c] = rsp_valid_o;
    end
    chk("reset_no_stale", 65'(vbits), 65'd0);
    exp_q.push_back(exp_rec(32'h4));
    drive_req(1'b1, 32'h4);
    tick();
    drive_req(1'b0, 32'h0);
    repeat (4) tick();
    chk("reset_mem_kept", 65'(exp_q.size()), 65'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
